// File: rtl/mem_access_unit.sv
// Memory access stage: aligns loads, merges sub-word stores with a read-modify-write, wraps addresses.
// Optional MISALIGN_TRAP_EN adds the misalign_o flag and suppresses misaligned accesses.
module mem_access_unit #(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] exmem_alu_i,
  input  logic [31:0] exmem_wdata_i,
  input  logic        exmem_m_MW_i,
  input  logic        exmem_m_MR_i,
  input  logic [1:0]  exmem_size_i,
  input  logic        exmem_unsigned_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] wb_data_o,
  output logic        wb_valid_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state_reg, state_next;
  logic [31:0] rmw_data_reg, rmw_addr_reg;
  logic [31:0] wb_data_reg;
  logic        wb_valid_reg;

  logic [31:0] eff_addr, aligned_addr;
  logic [1:0]  lane;
  logic [3:0]  byte_en;
  logic [31:0] merged_word;
  logic [31:0] rdata_shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        is_word, misaligned, capture_rmw, load_fire;

  assign eff_addr     = exmem_alu_i & 32'(MEM_BYTES - 1);
  assign aligned_addr = {eff_addr[31:2], 2'b00};
  assign lane         = eff_addr[1:0];
  assign is_word      = exmem_size_i[1];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((exmem_size_i == 2'b01) && eff_addr[0]) ||
                      (exmem_size_i[1] && (eff_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Halfwords always occupy lanes {addr[1],0} and {addr[1],1}; addr[0] is ignored.
  always_comb begin
    byte_en = 4'b1111;
    case (exmem_size_i)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = eff_addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] store_byte;
      assign store_byte = ((gi % 2 == 1) && (exmem_size_i == 2'b01)) ? exmem_wdata_i[15:8]
                                                                     : exmem_wdata_i[7:0];
      assign merged_word[8*gi +: 8] = byte_en[gi] ? store_byte : mem_rdata_i[8*gi +: 8];
    end
  endgenerate

  assign rdata_shifted = mem_rdata_i >> {lane, 3'b000};
  assign byte_sel      = rdata_shifted[7:0];
  assign half_sel      = eff_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    load_ext = mem_rdata_i;
    case (exmem_size_i)
      2'b00:   load_ext = exmem_unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = exmem_unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // Store wins over load; in RMW_WR the held inputs are ignored and the captured word is written.
  always_comb begin
    state_next  = state_reg;
    mem_we_o    = 1'b0;
    stall_o     = 1'b0;
    mem_addr_o  = aligned_addr;
    mem_wdata_o = exmem_wdata_i;
    capture_rmw = 1'b0;
    load_fire   = 1'b0;
    if (rst_i) begin
      case (state_reg)
        IDLE: begin
          if (exmem_m_MW_i) begin
            if (!misaligned) begin
              if (is_word) begin
                mem_we_o = 1'b1;
              end else begin
                stall_o     = 1'b1;
                capture_rmw = 1'b1;
                state_next  = RMW_WR;
              end
            end
          end else if (exmem_m_MR_i && !misaligned) begin
            load_fire = 1'b1;
          end
        end
        RMW_WR: begin
          mem_we_o    = 1'b1;
          mem_addr_o  = rmw_addr_reg;
          mem_wdata_o = rmw_data_reg;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      rmw_data_reg <= 32'h0;
      rmw_addr_reg <= 32'h0;
      wb_data_reg  <= 32'h0;
      wb_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wb_valid_reg <= load_fire;
      if (load_fire) wb_data_reg <= load_ext;
      if (capture_rmw) begin
        rmw_data_reg <= merged_word;
        rmw_addr_reg <= aligned_addr;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_reg;
  always_ff @(posedge clk_i) begin
    if (!rst_i) misalign_reg <= 1'b0;
    else        misalign_reg <= (state_reg == IDLE) && (exmem_m_MW_i || exmem_m_MR_i) && misaligned;
  end
  assign misalign_o = misalign_reg;
`endif

  assign wb_data_o  = wb_data_reg;
  assign wb_valid_o = wb_valid_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-wise reference memory, queued expected writes and loads.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] exmem_alu_i, exmem_wdata_i, mem_addr_o, mem_wdata_o, mem_rdata_i, wb_data_o;
  logic        exmem_m_MW_i, exmem_m_MR_i, exmem_unsigned_i, mem_we_o, stall_o, wb_valid_o;
  logic [1:0]  exmem_size_i;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.MEM_BYTES(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exmem_alu_i(exmem_alu_i), .exmem_wdata_i(exmem_wdata_i),
    .exmem_m_MW_i(exmem_m_MW_i), .exmem_m_MR_i(exmem_m_MR_i),
    .exmem_size_i(exmem_size_i), .exmem_unsigned_i(exmem_unsigned_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o),
    .wb_data_o(wb_data_o), .wb_valid_o(wb_valid_o)
`ifdef MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  logic [31:0] tb_mem  [8];
  logic [31:0] ref_mem [8];
  logic [63:0] wr_q [$];
  logic [31:0] ld_q [$];
  logic [31:0] last_wb;
  int checks = 0;
  int errors = 0;

  assign mem_rdata_i = tb_mem[mem_addr_o[4:2]];
  always @(posedge clk_i) if (mem_we_o) tb_mem[mem_addr_o[4:2]] <= mem_wdata_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    logic [63:0] we_exp;
    logic [31:0] ld_exp;
    if (mem_we_o) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'(mem_we_o), 32'd0);
      else begin
        we_exp = wr_q.pop_front();
        check("wr_addr", mem_addr_o, we_exp[63:32]);
        check("wr_data", mem_wdata_o, we_exp[31:0]);
      end
    end
    if (wb_valid_o) begin
      if (ld_q.size() == 0) check("ld_unexpected", 32'(wb_valid_o), 32'd0);
      else begin
        ld_exp = ld_q.pop_front();
        check("ld_data", wb_data_o, ld_exp);
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [4:0]  e = a[4:0];
    logic [31:0] w = ref_mem[e[4:2]];
    logic [7:0]  lo, hi;
    case (sz)
      2'b00: begin
        lo = w[8*e[1:0] +: 8];
        return uns ? {24'h0, lo} : {{24{lo[7]}}, lo};
      end
      2'b01: begin
        lo = w[16*e[1] +: 8];
        hi = w[16*e[1] + 8 +: 8];
        return uns ? {16'h0, hi, lo} : {{16{hi[7]}}, hi, lo};
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [4:0]  e = a[4:0];
    logic [31:0] w = ref_mem[e[4:2]];
    case (sz)
      2'b00:   w[8*e[1:0] +: 8] = d[7:0];
      2'b01:   w[16*e[1] +: 16] = d[15:0];
      default: w = d;
    endcase
    ref_mem[e[4:2]] = w;
    return w;
  endfunction

  task automatic clear_req();
    exmem_m_MW_i = 1'b0;
    exmem_m_MR_i = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input logic uns, input logic mw, input logic mr);
    exmem_alu_i = a; exmem_wdata_i = d; exmem_size_i = sz;
    exmem_unsigned_i = uns; exmem_m_MW_i = mw; exmem_m_MR_i = mr;
  endtask

  // Every stimulus task starts and ends 1 time unit after a rising edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input logic with_load);
    logic [31:0] w;
    w = model_store(a, sz, d);
    wr_q.push_back({a & 32'h1C, w});
    $display("ST addr=%h size=%0d data=%h load=%0d -> word %h", a, sz, d, with_load, w);
    drive(a, d, sz, 1'b0, 1'b1, with_load);
    @(negedge clk_i);
    if (sz[1]) begin
      check("st_word_stall", 32'(stall_o), 32'd0);
      check("st_word_we", 32'(mem_we_o), 32'd1);
    end else begin
      check("st_sub_stall", 32'(stall_o), 32'd1);
      check("st_sub_we", 32'(mem_we_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      check("rmw_stall", 32'(stall_o), 32'd0);
      check("rmw_we", 32'(mem_we_o), 32'd1);
    end
    @(posedge clk_i); #1;
    clear_req();
    if (with_load) begin
      @(negedge clk_i);
      check("st_ld_valid", 32'(wb_valid_o), 32'd0);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    v = model_load(a, sz, uns);
    ld_q.push_back(v);
    last_wb = v;
    $display("LD addr=%h size=%0d unsigned=%0d -> %h", a, sz, uns, v);
    drive(a, 32'h0, sz, uns, 1'b0, 1'b1);
    @(negedge clk_i);
    check("ld_stall", 32'(stall_o), 32'd0);
    check("ld_we", 32'(mem_we_o), 32'd0);
    @(posedge clk_i); #1;
    clear_req();
    @(negedge clk_i);
    check("ld_valid", 32'(wb_valid_o), 32'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    check("idle_we", 32'(mem_we_o), 32'd0);
    check("idle_stall", 32'(stall_o), 32'd0);
    check("idle_valid", 32'(wb_valid_o), 32'd0);
    check("idle_hold", wb_data_o, last_wb);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 8; i++) begin
      tb_mem[i]  = 32'h0;
      ref_mem[i] = 32'h0;
    end
    last_wb = 32'h0;
    rst_i = 1'b0;
    drive(32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
`ifdef MISALIGN_TRAP_EN
    check("rst_misalign", 32'(misalign_o), 32'd0);
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    do_store(32'd8, 32'hDEADBEEF, 2'b10, 1'b0);
    do_store(32'd4, 32'h11223344, 2'b10, 1'b0);
    do_store(32'd6, 32'h000000AA, 2'b00, 1'b0);
    do_load(32'd4, 2'b10, 1'b0);
    do_store(32'd4, 32'h80FF0102, 2'b10, 1'b0);
    do_load(32'd7, 2'b00, 1'b0);
    do_load(32'd7, 2'b00, 1'b1);
    idle_cycle();
    do_store(32'd33, 32'hCAFEF00D, 2'b10, 1'b0);
    do_store(32'd12, 32'h12345678, 2'b11, 1'b1);
    do_store(32'd18, 32'h0000BEEF, 2'b01, 1'b0);
    do_load(32'd18, 2'b01, 1'b0);
    do_load(32'd18, 2'b01, 1'b1);
    do_load(32'd16, 2'b10, 1'b0);

    // Reset while the merged word is pending: the write must never reach memory.
    $display("RST during RMW at addr=00000005");
    drive(32'd5, 32'h00000077, 2'b00, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    check("rstrmw_stall", 32'(stall_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rstrmw_we", 32'(mem_we_o), 32'd0);
    check("rstrmw_stall_lo", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    clear_req();
    last_wb = 32'h0;
    idle_cycle();
    do_load(32'd4, 2'b10, 1'b0);
    do_store(32'd20, 32'h0BADF00D, 2'b10, 1'b0);

`ifdef MISALIGN_TRAP_EN
    $display("MIS word store addr=00000002");
    drive(32'd2, 32'h55555555, 2'b10, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    check("mis_st_we", 32'(mem_we_o), 32'd0);
    check("mis_st_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    clear_req();
    @(negedge clk_i);
    check("mis_st_flag", 32'(misalign_o), 32'd1);
    @(posedge clk_i); #1;
    $display("MIS half load addr=00000005");
    drive(32'd5, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    clear_req();
    @(negedge clk_i);
    check("mis_ld_flag", 32'(misalign_o), 32'd1);
    check("mis_ld_valid", 32'(wb_valid_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("mis_flag_clear", 32'(misalign_o), 32'd0);
    @(posedge clk_i); #1;
    do_load(32'd0, 2'b10, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      a  = 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
`ifdef MISALIGN_TRAP_EN
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
`endif
      if ($urandom_range(0, 1) == 0) do_store(a, $urandom, sz, 1'b0);
      else do_load(a, sz, 1'($urandom_range(0, 1)));
    end
    idle_cycle();

    check("wrq_drained", 32'(wr_q.size()), 32'd0);
    check("ldq_drained", 32'(ld_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
